// File: rtl/pipeline_job_sequencer_pkg.sv
// Shared definitions for the job sequencer: FSM states, bus widths and
// the bit positions of the fields packed into a pipeline result word.
package pipeline_job_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_TOP = 3'd1,
        FEED     = 3'd2,
        DRAIN    = 3'd3,
        REPORT   = 3'd4
    } seq_state_t;

    localparam int BOT_W    = 128;
    localparam int RESULT_W = 64;

    // Result word layout: {13'b0, pcoeff[50:48], 10'b0, summed[37:0]}
    localparam int RES_SUMMED_LSB = 0;
    localparam int RES_SUMMED_W   = 38;
    localparam int RES_PCOEFF_LSB = 48;
    localparam int RES_PCOEFF_W   = 3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_job_sequencer_accumulator.sv
// Result side of the sequencer: extracts the result fields, sums them and
// tracks how many issued bots are still waiting for their result.
import pipeline_job_sequencer_pkg::*;

module job_result_accumulator #(
    parameter int BOT_CNT_W = 32,
    parameter int SUM_W     = 64,
    parameter int PCOEFF_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 issue,
    input  logic                 resultValid,
    input  logic [RESULT_W-1:0]  result,
    output logic [SUM_W-1:0]     sum,
    output logic [PCOEFF_W-1:0]  pcoeff,
    output logic [BOT_CNT_W-1:0] outstandingNext,
    output logic                 spurious
);

    logic [BOT_CNT_W-1:0]    outstanding;
    logic [RES_SUMMED_W-1:0] summedField;
    logic [RES_PCOEFF_W-1:0] pcoeffField;
    logic                    take;
    logic                    unusedResultBits;

    assign summedField = result[RES_SUMMED_LSB +: RES_SUMMED_W];
    assign pcoeffField = result[RES_PCOEFF_LSB +: RES_PCOEFF_W];
    // The padding bits of the result word carry no information.
    assign unusedResultBits = ^{result[RESULT_W-1:RES_PCOEFF_LSB+RES_PCOEFF_W],
                                result[RES_PCOEFF_LSB-1:RES_SUMMED_LSB+RES_SUMMED_W]};

    // A result only counts when some issued bot is still waiting for it.
    assign take = resultValid && (outstanding != '0);

    // Outstanding after this cycle: an issue and a taken result cancel out.
    always_comb begin
        outstandingNext = outstanding;
        if (issue && !take) begin
            outstandingNext = outstanding + 1'b1;
        end else if (!issue && take) begin
            outstandingNext = outstanding - 1'b1;
        end
    end

    // Accumulators, outstanding counter and the sticky spurious-result flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum         <= '0;
            pcoeff      <= '0;
            outstanding <= '0;
            spurious    <= 1'b0;
        end else begin
            if (resultValid && !take) begin
                spurious <= 1'b1;
            end
            if (clear) begin
                sum         <= '0;
                pcoeff      <= '0;
                outstanding <= '0;
            end else begin
                if (take) begin
                    sum    <= sum + SUM_W'(summedField);
                    pcoeff <= pcoeff + PCOEFF_W'(pcoeffField);
                end
                outstanding <= outstandingNext;
            end
        end
    end

endmodule

// File: rtl/pipeline_job_sequencer.sv
// Runs one job at a time through the permutation pipeline: loads the top,
// streams the job's bots under backpressure, waits for every result and
// then presents a single summary record.
import pipeline_job_sequencer_pkg::*;

module pipeline_job_sequencer #(
    parameter int BOT_CNT_W = 32,
    parameter int SUM_W     = 64,
    parameter int PCOEFF_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jobValid,
    output logic                 jobReady,
    input  logic [BOT_W-1:0]     jobTop,
    input  logic [BOT_CNT_W-1:0] jobBotCount,
    input  logic                 botInValid,
    output logic                 botInReady,
    input  logic [BOT_W-1:0]     botIn,
    output logic                 pipeStartNewTop,
    output logic [BOT_W-1:0]     pipeBot,
    output logic                 pipeBotValid,
    input  logic                 pipeReady,
    input  logic                 pipeResultValid,
    input  logic [RESULT_W-1:0]  pipeResult,
    output logic                 doneValid,
    input  logic                 doneReady,
    output logic [SUM_W-1:0]     doneSum,
    output logic [PCOEFF_W-1:0]  donePcoeff,
    output logic [31:0]          doneCycles,
    output logic                 errSpurious
);

    seq_state_t           state;
    seq_state_t           stateNext;
    logic [BOT_W-1:0]     topLatched;
    logic [BOT_CNT_W-1:0] botCount;
    logic [BOT_CNT_W-1:0] issued;
    logic [BOT_CNT_W-1:0] outstandingNext;
    logic [31:0]          cycleCount;
    logic                 accept;
    logic                 issue;
    logic                 lastIssue;

    assign accept     = (state == IDLE) && jobValid;
    assign issue      = (state == FEED) && botInValid && pipeReady;
    assign lastIssue  = issue && (issued == botCount - 1'b1);
    assign doneCycles = cycleCount;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Job descriptor capture; only meaningful once a job has been accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            topLatched <= jobTop;
            botCount   <= jobBotCount;
        end
    end

    // Issue counter and busy-cycle counter (counts LOAD_TOP/FEED/DRAIN cycles).
    always_ff @(posedge clk) begin
        if (rst) begin
            issued     <= '0;
            cycleCount <= '0;
        end else if (accept) begin
            issued     <= '0;
            cycleCount <= '0;
        end else begin
            if (issue) begin
                issued <= issued + 1'b1;
            end
            if (state inside {LOAD_TOP, FEED, DRAIN}) begin
                cycleCount <= sat_inc32(cycleCount);
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        stateNext       = state;
        jobReady        = 1'b0;
        botInReady      = 1'b0;
        pipeStartNewTop = 1'b0;
        pipeBot         = botIn;
        pipeBotValid    = 1'b0;
        doneValid       = 1'b0;
        case (state)
            IDLE: begin
                jobReady = 1'b1;
                if (jobValid) begin
                    stateNext = (jobBotCount == '0) ? REPORT : LOAD_TOP;
                end
            end
            LOAD_TOP: begin
                pipeStartNewTop = 1'b1;
                pipeBot         = topLatched;
                stateNext       = FEED;
            end
            FEED: begin
                pipeBotValid = botInValid;
                botInReady   = pipeReady;
                if (lastIssue) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (outstandingNext == '0) begin
                    stateNext = REPORT;
                end
            end
            REPORT: begin
                doneValid = 1'b1;
                if (doneReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    job_result_accumulator #(
        .BOT_CNT_W (BOT_CNT_W),
        .SUM_W     (SUM_W),
        .PCOEFF_W  (PCOEFF_W)
    ) u_acc (
        .clk             (clk),
        .rst             (rst),
        .clear           (accept),
        .issue           (issue),
        .resultValid     (pipeResultValid),
        .result          (pipeResult),
        .sum             (doneSum),
        .pcoeff          (donePcoeff),
        .outstandingNext (outstandingNext),
        .spurious        (errSpurious)
    );

endmodule

// File: tb/tb_pipeline_job_sequencer.sv
// Self-checking bench: the bench plays host, pipeline and summary consumer,
// and compares every output each cycle against a job-level model.
module tb_pipeline_job_sequencer;

    localparam int BW  = 32;
    localparam int SW  = 64;
    localparam int PW  = 32;
    localparam int LIM = 2000;
    localparam int P_IDLE = 0, P_LOAD = 1, P_FEED = 2, P_DRAIN = 3, P_REPORT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           jobValid, jobReady;
    logic [127:0]   jobTop;
    logic [BW-1:0]  jobBotCount;
    logic           botInValid, botInReady;
    logic [127:0]   botIn;
    logic           pipeStartNewTop;
    logic [127:0]   pipeBot;
    logic           pipeBotValid, pipeReady;
    logic           pipeResultValid;
    logic [63:0]    pipeResult;
    logic           doneValid, doneReady;
    logic [SW-1:0]  doneSum;
    logic [PW-1:0]  donePcoeff;
    logic [31:0]    doneCycles;
    logic           errSpurious;

    pipeline_job_sequencer #(.BOT_CNT_W(BW), .SUM_W(SW), .PCOEFF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .jobValid(jobValid), .jobReady(jobReady), .jobTop(jobTop), .jobBotCount(jobBotCount),
        .botInValid(botInValid), .botInReady(botInReady), .botIn(botIn),
        .pipeStartNewTop(pipeStartNewTop), .pipeBot(pipeBot), .pipeBotValid(pipeBotValid),
        .pipeReady(pipeReady), .pipeResultValid(pipeResultValid), .pipeResult(pipeResult),
        .doneValid(doneValid), .doneReady(doneReady), .doneSum(doneSum),
        .donePcoeff(donePcoeff), .doneCycles(doneCycles), .errSpurious(errSpurious)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Job-level model state
    int             ph;
    logic [127:0]   m_top;
    logic [31:0]    m_count, m_issued, m_out, m_cyc;
    logic [SW-1:0]  m_sum;
    logic [PW-1:0]  m_pc;
    bit             m_err;

    // Stimulus knobs and DUT activity counters
    int  v_mode, r_mode, res_mode;
    bit  spur_req, spur_rand, tgl;
    int  n_starts, n_iss;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_ok(input string name, input bit ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: wait bound of %0d cycles expired, required event did not occur", name, LIM);
        end
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle.
    task automatic model_step();
        bit          iss, take;
        logic [31:0] nout;
        if (rst) begin
            ph = P_IDLE; m_issued = 0; m_out = 0; m_sum = 0; m_pc = 0; m_cyc = 0; m_err = 0;
            return;
        end
        iss  = (ph == P_FEED) && botInValid && pipeReady;
        take = pipeResultValid && (m_out != 0);
        if (pipeResultValid && m_out == 0) m_err = 1;
        if (take) begin
            m_sum = m_sum + {26'b0, pipeResult[37:0]};
            m_pc  = m_pc + {29'b0, pipeResult[50:48]};
        end
        nout = m_out + {31'b0, iss} - {31'b0, take};
        if ((ph == P_LOAD || ph == P_FEED || ph == P_DRAIN) && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        case (ph)
            P_IDLE: if (jobValid) begin
                m_top = jobTop; m_count = jobBotCount; m_issued = 0;
                m_sum = 0; m_pc = 0; m_cyc = 0;
                ph = (jobBotCount == 0) ? P_REPORT : P_LOAD;
            end
            P_LOAD:   ph = P_FEED;
            P_FEED:   if (iss) begin
                m_issued = m_issued + 1;
                if (m_issued == m_count) ph = P_DRAIN;
            end
            P_DRAIN:  if (nout == 0) ph = P_REPORT;
            P_REPORT: if (doneReady) ph = P_IDLE;
            default:  ph = P_IDLE;
        endcase
        m_out = nout;
    endtask

    // Per-cycle bot source and pipeline behaviour.
    task automatic drive();
        botIn      = {$urandom(), $urandom(), $urandom(), $urandom()};
        botInValid = (v_mode == 1) ? 1'b1 : ($urandom_range(0, 99) < 70);
        case (r_mode)
            1: pipeReady = 1'b1;
            2: if (ph == P_FEED) begin pipeReady = tgl; tgl = ~tgl; end
               else begin pipeReady = 1'b0; tgl = 1'b1; end
            default: pipeReady = ($urandom_range(0, 99) < 70);
        endcase
        pipeResult      = {$urandom(), $urandom()};
        pipeResultValid = 1'b0;
        if (spur_req) begin
            pipeResultValid = 1'b1;
            spur_req = 1'b0;
        end else if (m_out != 0) begin
            if (res_mode == 0) pipeResultValid = ($urandom_range(0, 99) < 50);
            else if (res_mode == 1) begin
                pipeResultValid = 1'b1;
                pipeResult = {13'b0, 3'd1, 10'b0, 38'd5};
            end
        end else if (spur_rand) begin
            pipeResultValid = ($urandom_range(0, 99) < 3);
        end
    endtask

    // Compare every output against the model.
    task automatic compare();
        chk("jobReady",        jobReady,        ph == P_IDLE);
        chk("pipeStartNewTop", pipeStartNewTop, ph == P_LOAD);
        chk("pipeBot",         pipeBot,         (ph == P_LOAD) ? m_top : botIn);
        chk("pipeBotValid",    pipeBotValid,    (ph == P_FEED) && botInValid);
        chk("botInReady",      botInReady,      (ph == P_FEED) && pipeReady);
        chk("doneValid",       doneValid,       ph == P_REPORT);
        chk("doneSum",         doneSum,         m_sum);
        chk("donePcoeff",      donePcoeff,      m_pc);
        chk("doneCycles",      doneCycles,      m_cyc);
        chk("errSpurious",     errSpurious,     m_err);
        if (pipeStartNewTop === 1'b1) n_starts++;
        if (botInValid && botInReady === 1'b1) n_iss++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        drive();
        @(negedge clk);
        compare();
    endtask

    // Submit one job, wait for its summary, hold it, then release it.
    task automatic run_job(input logic [127:0] top, input logic [31:0] cnt, input int hold,
                           output int lat, output int starts, output int iss,
                           output logic [SW-1:0] sum, output logic [PW-1:0] pc, output logic [31:0] cyc);
        int s0, i0, g;
        s0 = n_starts; i0 = n_iss;
        jobTop = top; jobBotCount = cnt; jobValid = 1'b1;
        g = 0;
        while (ph == P_IDLE && g < LIM) begin cycle(); g++; end
        bound_ok("job_accept", g < LIM);
        jobValid = 1'b0;
        lat = 0; g = 0;
        while (doneValid !== 1'b1 && g < LIM) begin cycle(); lat++; g++; end
        bound_ok("job_done", g < LIM);
        doneReady = 1'b0;
        for (int k = 0; k < hold; k++) begin
            cycle();
            chk("doneValid_hold", doneValid, 1'b1);
        end
        sum = doneSum; pc = donePcoeff; cyc = doneCycles;
        starts = n_starts - s0; iss = n_iss - i0;
        doneReady = 1'b1;
        cycle();
        doneReady = 1'b0;
        chk("jobReady_after_done", jobReady, 1'b1);
        chk("doneValid_after_done", doneValid, 1'b0);
    endtask

    initial begin
        int lat, starts, iss, g;
        logic [SW-1:0] sum, e_sum;
        logic [PW-1:0] pc, e_pc;
        logic [31:0]   cyc;

        rst = 1'b1; jobValid = 1'b0; jobTop = '0; jobBotCount = '0; doneReady = 1'b0;
        botIn = '0; botInValid = 1'b0; pipeReady = 1'b0; pipeResultValid = 1'b0; pipeResult = '0;
        v_mode = 0; r_mode = 0; res_mode = 2; spur_req = 0; spur_rand = 0; tgl = 1;
        n_starts = 0; n_iss = 0;
        ph = P_IDLE; m_top = '0; m_count = 0; m_issued = 0; m_out = 0; m_cyc = 0;
        m_sum = '0; m_pc = '0; m_err = 0;

        // Reset state
        repeat (3) cycle();
        chk("rst_jobReady",        jobReady,        1'b1);
        chk("rst_pipeStartNewTop", pipeStartNewTop, 1'b0);
        chk("rst_pipeBotValid",    pipeBotValid,    1'b0);
        chk("rst_botInReady",      botInReady,      1'b0);
        chk("rst_doneValid",       doneValid,       1'b0);
        chk("rst_doneSum",         doneSum,         64'd0);
        chk("rst_doneCycles",      doneCycles,      32'd0);
        chk("rst_errSpurious",     errSpurious,     1'b0);
        rst = 1'b0;
        cycle();

        // count=3, bots always valid, pipeReady=1, each result {pc=1,sum=5}
        v_mode = 1; r_mode = 1; res_mode = 1;
        run_job(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 3, 10, lat, starts, iss, sum, pc, cyc);
        chk("t3_starts",     starts, 1);
        chk("t3_issues",     iss,    3);
        chk("t3_doneSum",    sum,    64'd15);
        chk("t3_donePcoeff", pc,     32'd3);
        chk("t3_cycles",     cyc,    32'd5);
        chk("t3_latency",    lat,    5);
        chk("t3_errSpur",    errSpurious, 1'b0);
        chk("t3_model_sum",  m_sum,  64'd15);

        // count=0: straight to the summary with zero sums
        v_mode = 0; r_mode = 0; res_mode = 0;
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 2, lat, starts, iss, sum, pc, cyc);
        chk("t0_latency",  lat,    0);
        chk("t0_starts",   starts, 0);
        chk("t0_issues",   iss,    0);
        chk("t0_doneSum",  sum,    64'd0);
        chk("t0_pcoeff",   pc,     32'd0);

        // count=4 with pipeReady toggling 1,0,1,0 during FEED
        v_mode = 1; r_mode = 2; res_mode = 0;
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 4, 1, lat, starts, iss, sum, pc, cyc);
        chk("t4_issues", iss,    4);
        chk("t4_starts", starts, 1);
        cycle();

        // Spurious result while idle: sticky flag, accumulators untouched
        e_sum = m_sum; e_pc = m_pc;
        spur_req = 1'b1;
        repeat (2) cycle();
        chk("spur_flag",      errSpurious, 1'b1);
        chk("spur_sum_kept",  doneSum,     e_sum);
        chk("spur_pc_kept",   donePcoeff,  e_pc);
        repeat (5) cycle();
        chk("spur_sticky",    errSpurious, 1'b1);

        // Randomised jobs
        spur_rand = 1'b1;
        for (int j = 0; j < 25; j++) begin
            v_mode = $urandom_range(0, 1); r_mode = $urandom_range(0, 1); res_mode = $urandom_range(0, 1);
            run_job({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom_range(0, 12),
                    $urandom_range(0, 4), lat, starts, iss, sum, pc, cyc);
            chk("rnd_issues", iss, j < 0 ? 0 : m_count);
            repeat ($urandom_range(0, 2)) cycle();
        end
        spur_rand = 1'b0;

        // Reset in FEED after 2 of 5 issues
        v_mode = 1; r_mode = 1; res_mode = 2;
        jobTop = {$urandom(), $urandom(), $urandom(), $urandom()}; jobBotCount = 5; jobValid = 1'b1;
        g = 0;
        while (ph == P_IDLE && g < LIM) begin cycle(); g++; end
        bound_ok("rst_job_accept", g < LIM);
        jobValid = 1'b0;
        g = 0;
        while (m_issued < 2 && g < LIM) begin cycle(); g++; end
        bound_ok("rst_two_issues", g < LIM);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_jobReady",   jobReady,    1'b1);
        chk("midrst_doneValid",  doneValid,   1'b0);
        chk("midrst_botInReady", botInReady,  1'b0);
        chk("midrst_doneSum",    doneSum,     64'd0);
        chk("midrst_donePcoeff", donePcoeff,  32'd0);
        chk("midrst_doneCycles", doneCycles,  32'd0);
        chk("midrst_errSpur",    errSpurious, 1'b0);

        // A job after the reset still completes normally
        res_mode = 1;
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 0, lat, starts, iss, sum, pc, cyc);
        chk("post_rst_sum",    sum, 64'd10);
        chk("post_rst_issues", iss, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
